alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the 8-bit ALU operand/opcode interface.
- Accepts operation commands (opcode plus two operands) over a valid/ready stream and buffers them in a small FIFO.
- Drives one command at a time onto the ALU's in1/in2/operation/rst ports, captures the ALU result, and returns it over a valid/ready response stream.
- Sits between a host/sequencer and the combinational ALU, giving the ALU a clocked, flow-controlled front end.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- ISSUE_WAIT, 1, cycles the ALU inputs are held before the result is sampled; 1 to 15.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  4  ALU opcode.
- cmd_a  in  8  operand 1.
- cmd_b  in  8  operand 2.
- alu_in1  out  8  to ALU operand 1.
- alu_in2  out  8  to ALU operand 2.
- alu_op  out  4  to ALU operation select.
- alu_rst  out  1  to ALU rst.
- alu_out  in  8  ALU result (combinational from ALU).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  8  captured result.
- rsp_op  out  4  opcode that produced rsp_data.
- rsp_err  out  1  command was rejected (see Optional Feature); 0 otherwise.
- busy  out  1  FIFO non-empty or state != IDLE.

Behaviour:
- Clocking and reset: single clock, clk; rst is synchronous and active-high.
- Reset values: FIFO empty, state IDLE, cmd_ready=1, alu_in1/alu_in2/alu_op=0, alu_rst=1, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0, busy=0.
- Reset mid-operation discards all queued and in-flight commands. No response is produced for them.
- FIFO push/pop:
  - Push on the edge where cmd_valid && cmd_ready.
  - cmd_ready = !full, from registered count. A pop in the same cycle does not raise cmd_ready when full.
  - Push and pop in the same cycle while not full: count unchanged, both take effect.
  - Read/write pointers wrap modulo FIFO_DEPTH. Commands are issued strictly in arrival order.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - alu_rst=1.
  - If FIFO non-empty: pop head, load alu_in1/alu_in2/alu_op, clear wait counter, go to DRIVE. Otherwise stay.
- DRIVE:
  - alu_rst=0; ALU inputs held constant; counter increments each cycle.
  - On the edge ending the ISSUE_WAIT-th DRIVE cycle: rsp_data<=alu_out, rsp_op<=alu_op, rsp_err<=0, rsp_valid<=1, go to RESP.
- RESP:
  - alu_rst=1. rsp_valid/rsp_data/rsp_op/rsp_err held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid<=0, go to IDLE.
  - rsp_ready while rsp_valid=0 has no effect.
- Latency (ISSUE_WAIT=1, empty FIFO, rsp_ready=1):
  - Command accepted at edge E; pop at E+1; rsp_valid high after E+2.
  - Throughput is one result per ISSUE_WAIT+2 cycles.
- Width rule: result is the ALU's 8-bit output verbatim. Overflow/wrap is the ALU's, not corrected here.
- alu_in1/alu_in2/alu_op retain the last issued values outside DRIVE.

Optional Feature:
- Macro: ALU_DIVZERO_GUARD_EN.
- Defined:
  - In IDLE, a popped command with cmd_op=4'b0011 and b=0 is not driven to the ALU (state skips DRIVE).
  - Next edge: rsp_data<=8'hFF, rsp_op<=4'b0011, rsp_err<=1, rsp_valid<=1, state RESP.
  - Response latency is one cycle shorter than a normal command.
- Undefined:
  - The command is issued normally and rsp_data is whatever the ALU returns.
  - rsp_err is tied to 0.

Test Plan:
- Reset then cmd op=0000 a=0x12 b=0x34, rsp_ready=1 -> rsp_valid two cycles after accept, rsp_data=0x46, rsp_op=0000, rsp_err=0, busy falls the cycle after the handshake.
- op=0001 a=0x05 b=0x07 -> rsp_data=0xFE (wrap). op=1100 a=0x09 b=0x03 -> rsp_data=0x01.
- rsp_ready=0, push 5 commands back-to-back -> 4 accepted into the FIFO, one more after the first pop. cmd_ready low when full. With rsp_ready raised, results return in order and rsp_data is stable while stalled.
- With ALU_DIVZERO_GUARD_EN: op=0011 a=0x40 b=0x00 -> rsp_data=0xFF, rsp_err=1, alu_rst stays 1 throughout. Then op=0011 a=0x40 b=0x08 -> 0x08, rsp_err=0.
- Queue 3 commands, assert rst for 1 cycle during DRIVE of the first -> no rsp_valid, cmd_ready=1, busy=0, alu_rst=1 next cycle. A new command afterwards completes correctly.
- ISSUE_WAIT=3 build: single op=0111 a=0xF0 b=0x3C -> rsp_valid 4 cycles after accept, rsp_data=0x30.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Purpose : clocked, flow-controlled front end for the 8-bit combinational ALU.
// Latency : accept at E, pop at E+1, rsp_valid after E+ISSUE_WAIT+1; one result per ISSUE_WAIT+2 cycles.
// Backpr. : cmd_ready = !full of a FIFO_DEPTH command FIFO; a held response stalls issue.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command stream; cmd_op/cmd_a/cmd_b payload
//   alu_in1/alu_in2/alu_op/alu_rst  registered drive to the ALU
//   alu_out                       ALU result (combinational from the ALU)
//   rsp_valid/rsp_ready           response stream; rsp_data/rsp_op/rsp_err payload
//   busy                          FIFO non-empty or a command in flight
// Optional feature macro: ALU_DIVZERO_GUARD_EN (divide-by-zero commands answered
// locally with 8'hFF and rsp_err=1; without it rsp_err is tied to 0).

// Small generic FIFO: registered count, full/empty derived from it.
// Latency: data written at a push edge is visible at the head after that edge.
// Backpressure: in_rdy = !full; a pop in the same cycle does not raise in_rdy.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign in_rdy  = (count != CW'(DEPTH));
  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end
endmodule

module alu_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ISSUE_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [3:0] alu_op,
  output logic       alu_rst,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_op,
  output logic       rsp_err,
  output logic       busy
);
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(ISSUE_WAIT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  cmd_t       fifo_in_dat;
  cmd_t       head;
  logic       fifo_out_vld;
  logic       fifo_out_rdy;

  assign fifo_in_dat  = '{op: cmd_op, a: cmd_a, b: cmd_b};
  // The head is consumed only from IDLE; DRIVE and RESP hold the FIFO.
  assign fifo_out_rdy = (state == IDLE);

  alu_cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .in_vld (cmd_valid),
    .in_rdy (cmd_ready),
    .in_dat (fifo_in_dat),
    .out_vld(fifo_out_vld),
    .out_rdy(fifo_out_rdy),
    .out_dat(head)
  );

  assign busy = fifo_out_vld || (state != IDLE);

`ifdef ALU_DIVZERO_GUARD_EN
  logic guard_hit;
  assign guard_hit = (head.op == 4'b0011) && (head.b == 8'h00);
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_op    <= '0;
      alu_rst   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
`ifdef ALU_DIVZERO_GUARD_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          alu_rst <= 1'b1;
          if (fifo_out_vld) begin
`ifdef ALU_DIVZERO_GUARD_EN
            if (guard_hit) begin
              // Answer locally; the ALU never sees this command.
              rsp_data  <= 8'hFF;
              rsp_op    <= 4'b0011;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
`endif
              alu_in1  <= head.a;
              alu_in2  <= head.b;
              alu_op   <= head.op;
              alu_rst  <= 1'b0;
              wait_cnt <= '0;
              state    <= DRIVE;
`ifdef ALU_DIVZERO_GUARD_EN
            end
`endif
          end
        end
        DRIVE: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == LAST_WAIT) begin
            rsp_data  <= alu_out;
            rsp_op    <= alu_op;
`ifdef ALU_DIVZERO_GUARD_EN
            rsp_err   <= 1'b0;
`endif
            rsp_valid <= 1'b1;
            alu_rst   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
  localparam int IW = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [7:0] alu_in1, alu_in2;
  logic [3:0] alu_op;
  logic       alu_rst;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [3:0] rsp_op;
  logic       rsp_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.FIFO_DEPTH(4), .ISSUE_WAIT(IW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_rst(alu_rst),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Behavioural stand-in for the external combinational ALU.
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: begin p = a * b; return p[7:0]; end
      4'h3: return (b == 8'h00) ? 8'h00 : a / b;
      4'h7: return a & b;
      4'hC: return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_out = alu_rst ? 8'h00 : alu_ref(alu_op, alu_in1, alu_in2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  // Single command with rsp_ready held high, starting from an idle DUT.
  task automatic run_one(input vec_t v, input string tag);
    int lat;
    int rst_lo;
    @(negedge clk);
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_valid = 1'b1;
    check($sformatf("%s_cmd_ready", tag), cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; rst_lo = 0;
    while (!rsp_valid && lat < 40) begin
      if (!alu_rst) rst_lo++;
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s_latency", tag), lat, v.exp_lat);
    check($sformatf("%s_alu_rst_low_cycles", tag), rst_lo, v.exp_err ? 0 : IW);
    check($sformatf("%s_rsp_data", tag), rsp_data, v.exp_data);
    check($sformatf("%s_rsp_op", tag), rsp_op, v.op);
    check($sformatf("%s_rsp_err", tag), rsp_err, v.exp_err);
    @(negedge clk);
    check($sformatf("%s_rsp_valid_drop", tag), rsp_valid, 0);
    check($sformatf("%s_busy_drop", tag), busy, 0);
    check($sformatf("%s_alu_rst_idle", tag), alu_rst, 1);
    if (!v.exp_err) begin
      check($sformatf("%s_alu_in1_kept", tag), alu_in1, v.a);
      check($sformatf("%s_alu_in2_kept", tag), alu_in2, v.b);
      check($sformatf("%s_alu_op_kept", tag), alu_op, v.op);
    end
  endtask

  initial begin
    logic [11:0] exp_q[$];
    logic [11:0] front;
    logic [7:0]  held;
    int n;
    int seen;

    vecs[0] = '{4'h0, 8'h12, 8'h34, 8'h46, 1'b0, IW + 1};
    vecs[1] = '{4'h1, 8'h05, 8'h07, 8'hFE, 1'b0, IW + 1};
    vecs[2] = '{4'hC, 8'h09, 8'h03, 8'h01, 1'b0, IW + 1};
    vecs[3] = '{4'h7, 8'hF0, 8'h3C, 8'h30, 1'b0, IW + 1};
    vecs[4] = '{4'h3, 8'h40, 8'h08, 8'h08, 1'b0, IW + 1};
`ifdef ALU_DIVZERO_GUARD_EN
    vecs[5] = '{4'h3, 8'h40, 8'h00, 8'hFF, 1'b1, 1};
`else
    vecs[5] = '{4'h3, 8'h40, 8'h00, 8'h00, 1'b0, IW + 1};
`endif
    vecs[6] = '{4'h0, 8'hFF, 8'h02, 8'h01, 1'b0, IW + 1};
    vecs[7] = '{4'h2, 8'h10, 8'h11, 8'h10, 1'b0, IW + 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_in2", alu_in2, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_rst", alu_rst, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_op", rsp_op, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Table-driven single commands
    for (int i = 0; i < 8; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Stalled consumer: fill in-flight slot plus the whole FIFO
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_op = (i % 2 == 1) ? 4'h1 : 4'h0;
      cmd_a = 8'(16 * i + 3);
      cmd_b = 8'(i + 9);
      cmd_valid = 1'b1;
      check($sformatf("fill%0d_cmd_ready", i), cmd_ready, 1);
      exp_q.push_back({cmd_op, alu_ref(cmd_op, cmd_a, cmd_b)});
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    check("stall_rsp_valid", rsp_valid, 1);
    held = rsp_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("stall%0d_rsp_data", i), rsp_data, held);
      check($sformatf("stall%0d_cmd_ready", i), cmd_ready, 0);
    end
    // Release: sixth command waits until the FIFO truly has room
    rsp_ready = 1'b1;
    cmd_op = 4'h7; cmd_a = 8'hAA; cmd_b = 8'h0F; cmd_valid = 1'b1;
    check("release_cmd_ready", cmd_ready, 0);
    front = exp_q.pop_front();
    check("order0_data", rsp_data, front[7:0]);
    check("order0_op", rsp_op, front[11:8]);
    @(negedge clk);
    check("pop_cycle_rsp_valid", rsp_valid, 0);
    check("pop_cycle_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    check("after_pop_cmd_ready", cmd_ready, 1);
    exp_q.push_back({4'h7, 8'h0A});
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0; seen = 1;
    while (exp_q.size() > 0 && n < 200) begin
      if (rsp_valid) begin
        front = exp_q.pop_front();
        check($sformatf("order%0d_data", seen), rsp_data, front[7:0]);
        check($sformatf("order%0d_op", seen), rsp_op, front[11:8]);
        seen++;
      end
      @(negedge clk);
      n++;
    end
    check("drain_count", seen, 6);
    check("drain_busy", busy, 0);

    // Reset during DRIVE of the first of three queued commands
    @(negedge clk);
    cmd_op = 4'h0; cmd_a = 8'h11; cmd_b = 8'h22; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_op = 4'h1; cmd_a = 8'h33; cmd_b = 8'h01;
    @(negedge clk);
    check("pre_rst_alu_rst_drive", alu_rst, 0);
    cmd_op = 4'h7; cmd_a = 8'h55; cmd_b = 8'h0F;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_alu_rst", alu_rst, 1);
    check("midrst_alu_in1", alu_in1, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) n++;
    end
    check("midrst_no_activity", n, 0);
    run_one('{4'h0, 8'h12, 8'h34, 8'h46, 1'b0, IW + 1}, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
